sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Downstream stage of the SRAM buffer. Accepts its level-held wen/ren/addr/wdata requests and performs single-word accesses to a 1R1W 32-bit storage array with a fixed multi-cycle latency.
- Reports progress on the 2-bit sram_state bus (IDLE/BUSY/DONE/ERROR) that the buffer FSM polls.
- Read data is presented on rdata and is valid in the DONE cycle.

Parameters:
- ADDR_W, 10, address width.
- DATA_W, 32, word width.
- DEPTH, 1024, number of words; must be ≤ 2**ADDR_W.
- LATENCY, 2, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- wen  in  1  write request, level, held until DONE/ERROR.
- ren  in  1  read request, level, held until DONE/ERROR.
- addr  in  ADDR_W  word address, sampled at commit.
- wdata  in  DATA_W  write data, sampled at commit.
- rdata  out  DATA_W  read data; valid in DONE, held until the next read commit.
- sram_state  out  2  00 IDLE, 01 BUSY, 10 DONE, 11 ERROR.

Behaviour:
- Reset values: sram_state=IDLE, rdata=0, busy counter=0, latched op=none. Array contents are not reset; reading an unwritten word is undefined.
- The FSM state is the registered sram_state.
- IDLE:
  - wen^ren → BUSY; latch op (W or R); load counter with LATENCY-1.
  - wen&ren → ERROR; no access.
  - Neither → stay in IDLE.
- BUSY:
  - Request dropped (wen=ren=0) → IDLE next cycle; no commit (abort).
  - Request op differs from latched op, or both asserted → ERROR; no commit.
  - Otherwise, if counter≠0, decrement and stay.
  - Counter==0 is the commit cycle. Sample addr/wdata this cycle.
    - W: mem[addr]<=wdata.
    - R: rdata<=mem[addr].
    - Then → DONE.
  - addr ≥ DEPTH at commit → ERROR; no write; rdata unchanged.
- Late sampling is decided: the upstream FSM may present a stale or zero address in the first request cycle. Only the commit-cycle values are used.
- DONE: one cycle only, then unconditionally → IDLE, even if a request is still asserted. A held request starts a new access only from IDLE.
- ERROR: one cycle, then → IDLE.
- Latency from IDLE request to DONE is LATENCY+1 cycles. Back-to-back accesses are spaced LATENCY+2 cycles apart (DONE→IDLE→BUSY).
- Reset asserted mid-access: immediate return to IDLE; no commit; array untouched except for writes that already committed.
- rdata is never modified by writes, aborts or errors.

Optional Feature:
- Macro SRAM_CTRL_PARITY_EN.
- Defined:
  - Array is DATA_W+1 bits wide; the extra bit stores even parity of wdata.
  - Extra input par_inject (1 bit): when high at a write commit, the stored parity bit is inverted.
  - Read commit with parity mismatch → ERROR instead of DONE; rdata is still updated (debug visibility).
- Undefined: no parity bit, no par_inject port, and reads never produce ERROR from data content.

Decomposition:
- sram_pkg: sram_state_t enum (IDLE=2'b00, BUSY=2'b01, DONE=2'b10, ERROR=2'b11) and SRAM_ADDR_W/SRAM_DATA_W constants. The buffer and this block both import it.
- One sub-module, sram_array: synchronous 1R1W storage with we, re, addr, din, dout, parameterised by width and depth. It holds no FSM.

Test Plan:
- Write then read, LATENCY=2:
  - Hold wen, addr=0x005, wdata=0xDEADBEEF → sram_state 00,01,01,10,00.
  - Then hold ren, addr=0x005 → DONE on the 4th cycle with rdata=0xDEADBEEF.
- Late address:
  - Request cycle addr=0/wdata=0, then addr=0x010/wdata=0x12345678 for the BUSY cycles.
  - Required: read of 0x010 returns 0x12345678; read of 0x000 keeps its prior value 0xA5A5A5A5.
- Conflicts:
  - wen=ren=1 in IDLE → one ERROR cycle, then IDLE, no write.
  - wen switching to ren in the first BUSY cycle → ERROR, target word unchanged.
- Abort and reset:
  - Drop wen in the first BUSY cycle → IDLE next cycle; mem[0x020] keeps its old value 0x0.
  - Assert n_rst low during BUSY → sram_state=00 and rdata=0 asynchronously.
- Upstream sequence: drive the buffer's two-word pattern (low word 0x2, high word 0x3, request held across DONE→IDLE).
  - Required: exactly two commits, DONE seen twice, and no spurious third access.
- Parity (SRAM_CTRL_PARITY_EN):
  - Write 0x0000FFFF to 0x007 with par_inject=1, then read 0x007 → ERROR, rdata=0x0000FFFF.
  - Write again with par_inject=0, then read → DONE.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM handshake types and default widths, imported by the buffer FSM and sram_ctrl.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 10;
   localparam int unsigned SRAM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY  = 2'b01,
      DONE  = 2'b10,
      ERROR = 2'b11
   } sram_state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_W    = 2'b01,
      OP_R    = 2'b10
   } sram_op_t;

endpackage

// File: rtl/sram_array.sv
// Synchronous 1R1W word storage; contents are not reset, the read register is.
module sram_array #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   // Read register only moves on a read enable, so it holds across writes and errors.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)  dout <= '0;
      else if (re) dout <= mem[addr];
   end

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle single-word access controller reporting IDLE/BUSY/DONE/ERROR to the buffer FSM.
// Optional stored-parity checking is enabled with SRAM_CTRL_PARITY_EN.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W  = SRAM_ADDR_W,
   parameter int unsigned DATA_W  = SRAM_DATA_W,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              wen,
   input  logic              ren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_CTRL_PARITY_EN
   input  logic              par_inject,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        sram_state
);

   localparam int unsigned CNT_W = 4;
`ifdef SRAM_CTRL_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

   sram_state_t      state_q, state_d;
   sram_op_t         op_q, op_d, req_op_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_we_c, mem_re_c, addr_ok_c;
   logic [MEM_W-1:0] mem_din_c, mem_dout;

   assign addr_ok_c = ({1'b0, addr} < DEPTH_L);

   always_comb begin
      req_op_c = OP_NONE;
      if (wen && !ren)      req_op_c = OP_W;
      else if (ren && !wen) req_op_c = OP_R;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         op_q    <= OP_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      mem_we_c = 1'b0;
      mem_re_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (wen && ren) begin
               state_d = ERROR;
            end else if (wen || ren) begin
               state_d = BUSY;
               op_d    = req_op_c;
               cnt_d   = CNT_START;
            end
         end
         BUSY: begin
            if (!wen && !ren) begin
               state_d = IDLE;
               op_d    = OP_NONE;
               cnt_d   = '0;
            end else if (req_op_c != op_q) begin
               // Covers both an op switch and wen&ren together.
               state_d = ERROR;
               op_d    = OP_NONE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!addr_ok_c) begin
               state_d = ERROR;
               op_d    = OP_NONE;
            end else begin
               mem_we_c = (op_q == OP_W);
               mem_re_c = (op_q == OP_R);
               state_d  = DONE;
            end
         end
         DONE, ERROR: begin
            state_d = IDLE;
            op_d    = OP_NONE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            op_d    = OP_NONE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef SRAM_CTRL_PARITY_EN
   logic par_bad_c;

   assign mem_din_c = {(^wdata) ^ par_inject, wdata};
   assign par_bad_c = ^mem_dout;
   assign rdata     = mem_dout[DATA_W-1:0];

   // Parity is only known once the read register loads, so a read DONE is reported as ERROR.
   assign sram_state = (state_q == DONE && op_q == OP_R && par_bad_c) ? ERROR : state_q;
`else
   assign mem_din_c  = wdata;
   assign rdata      = mem_dout;
   assign sram_state = state_q;
`endif

   sram_array #(
      .ADDR_W (ADDR_W),
      .WIDTH  (MEM_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .n_rst (n_rst),
      .we    (mem_we_c),
      .re    (mem_re_c),
      .addr  (addr),
      .din   (mem_din_c),
      .dout  (mem_dout)
   );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl (LATENCY=2, DEPTH=1000 to reach the range check).
module tb_sram_ctrl;

   localparam int unsigned LAT = 2;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;
   localparam logic [1:0] ST_ERROR = 2'b11;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        wen = 1'b0;
   logic        ren = 1'b0;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [1:0]  sram_state;
`ifdef SRAM_CTRL_PARITY_EN
   logic        par_inject = 1'b0;
`endif

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_rd = '0;
   int          dones;

   always #5 clk = ~clk;

   sram_ctrl #(
      .ADDR_W  (10),
      .DATA_W  (32),
      .DEPTH   (1000),
      .LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .wen        (wen),
      .ren        (ren),
      .addr       (addr),
      .wdata      (wdata),
`ifdef SRAM_CTRL_PARITY_EN
      .par_inject (par_inject),
`endif
      .rdata      (rdata),
      .sram_state (sram_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full access from IDLE; rdata must equal exp_rd at the end state (writes pass last_rd).
   task automatic access(input logic is_wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [1:0] exp_end, input logic [31:0] exp_rd, input string tag);
      check({tag, "_idle"}, 32'(sram_state), 32'(ST_IDLE));
      wen = is_wr; ren = !is_wr; addr = a; wdata = d;
      for (int i = 0; i < int'(LAT); i++) begin
         tick();
         check({tag, "_busy"}, 32'(sram_state), 32'(ST_BUSY));
      end
      tick();
      check({tag, "_end"}, 32'(sram_state), 32'(exp_end));
      check({tag, "_rdata"}, rdata, exp_rd);
      last_rd = exp_rd;
      wen = 1'b0; ren = 1'b0;
      tick();
      check({tag, "_back_idle"}, 32'(sram_state), 32'(ST_IDLE));
   endtask

   initial begin
      #12;
      check("rst_state", 32'(sram_state), 32'(ST_IDLE));
      check("rst_rdata", rdata, 32'h0);
      n_rst = 1'b1;
      tick();
      check("post_rst_state", 32'(sram_state), 32'(ST_IDLE));

      // Write then read back
      access(1'b1, 10'h005, 32'hDEADBEEF, ST_DONE, last_rd, "wr5");
      access(1'b0, 10'h005, 32'h0, ST_DONE, 32'hDEADBEEF, "rd5");

      // Late address: only commit-cycle addr/wdata matter
      access(1'b1, 10'h000, 32'hA5A5A5A5, ST_DONE, last_rd, "wr0");
      wen = 1'b1; addr = 10'h000; wdata = 32'h0;
      tick();
      check("late_busy", 32'(sram_state), 32'(ST_BUSY));
      addr = 10'h010; wdata = 32'h12345678;
      tick();
      tick();
      check("late_done", 32'(sram_state), 32'(ST_DONE));
      wen = 1'b0;
      tick();
      access(1'b0, 10'h010, 32'h0, ST_DONE, 32'h12345678, "rd10");
      access(1'b0, 10'h000, 32'h0, ST_DONE, 32'hA5A5A5A5, "rd0");

      // Conflict in IDLE
      access(1'b1, 10'h030, 32'h11111111, ST_DONE, last_rd, "wr30");
      wen = 1'b1; ren = 1'b1; addr = 10'h030; wdata = 32'h99999999;
      tick();
      check("both_idle_err", 32'(sram_state), 32'(ST_ERROR));
      wen = 1'b0; ren = 1'b0;
      tick();
      check("both_idle_back", 32'(sram_state), 32'(ST_IDLE));
      access(1'b0, 10'h030, 32'h0, ST_DONE, 32'h11111111, "rd30a");

      // Op switch in first BUSY cycle
      wen = 1'b1; addr = 10'h030; wdata = 32'h22222222;
      tick();
      check("switch_busy", 32'(sram_state), 32'(ST_BUSY));
      wen = 1'b0; ren = 1'b1;
      tick();
      check("switch_err", 32'(sram_state), 32'(ST_ERROR));
      check("switch_rdata", rdata, 32'h11111111);
      ren = 1'b0;
      tick();
      check("switch_back", 32'(sram_state), 32'(ST_IDLE));
      access(1'b0, 10'h030, 32'h0, ST_DONE, 32'h11111111, "rd30b");

      // Abort by dropping the request
      access(1'b1, 10'h020, 32'h0, ST_DONE, last_rd, "wr20");
      wen = 1'b1; addr = 10'h020; wdata = 32'hCAFEF00D;
      tick();
      check("abort_busy", 32'(sram_state), 32'(ST_BUSY));
      wen = 1'b0;
      tick();
      check("abort_idle", 32'(sram_state), 32'(ST_IDLE));
      tick();
      check("abort_stay", 32'(sram_state), 32'(ST_IDLE));
      access(1'b0, 10'h020, 32'h0, ST_DONE, 32'h0, "rd20");

      // Address range boundary (DEPTH=1000)
      access(1'b0, 10'h005, 32'h0, ST_DONE, 32'hDEADBEEF, "rd5b");
      access(1'b1, 10'h3E8, 32'h77777777, ST_ERROR, last_rd, "wr_oor");
      access(1'b0, 10'h3E8, 32'h0, ST_ERROR, 32'hDEADBEEF, "rd_oor");
      access(1'b1, 10'h3E7, 32'h0BADF00D, ST_DONE, last_rd, "wr_last");
      access(1'b0, 10'h3E7, 32'h0, ST_DONE, 32'h0BADF00D, "rd_last");

      // Upstream two-word sequence, request held across DONE->IDLE
      dones = 0;
      wen = 1'b1; ren = 1'b0; addr = 10'h040; wdata = 32'h2;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (sram_state == ST_DONE) begin
            dones++;
            if (dones == 1) begin
               addr = 10'h041; wdata = 32'h3;
            end else begin
               wen = 1'b0;
            end
         end
      end
      check("seq_dones", 32'(dones), 32'd2);
      check("seq_idle", 32'(sram_state), 32'(ST_IDLE));
      access(1'b0, 10'h040, 32'h0, ST_DONE, 32'h2, "rd40");
      access(1'b0, 10'h041, 32'h0, ST_DONE, 32'h3, "rd41");

`ifdef SRAM_CTRL_PARITY_EN
      par_inject = 1'b1;
      access(1'b1, 10'h007, 32'h0000FFFF, ST_DONE, last_rd, "par_wr_bad");
      par_inject = 1'b0;
      access(1'b0, 10'h007, 32'h0, ST_ERROR, 32'h0000FFFF, "par_rd_bad");
      access(1'b1, 10'h007, 32'h0000FFFF, ST_DONE, last_rd, "par_wr_ok");
      access(1'b0, 10'h007, 32'h0, ST_DONE, 32'h0000FFFF, "par_rd_ok");
`endif

      // Asynchronous reset in the middle of an access
      wen = 1'b1; addr = 10'h050; wdata = 32'h55555555;
      tick();
      check("rst_mid_busy", 32'(sram_state), 32'(ST_BUSY));
      #2 n_rst = 1'b0;
      #1;
      check("rst_mid_state", 32'(sram_state), 32'(ST_IDLE));
      check("rst_mid_rdata", rdata, 32'h0);
      wen = 1'b0;
      #2 n_rst = 1'b1;
      last_rd = 32'h0;
      tick();
      check("rst_mid_after", 32'(sram_state), 32'(ST_IDLE));
      access(1'b0, 10'h005, 32'h0, ST_DONE, 32'hDEADBEEF, "rd5_post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
